// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx sequencing logic: controller state encoding,
// default idle timeout and the rx_en decode used by the controller FSM.
package uart_pkg;

    typedef enum logic [1:0] {
        CTRL_OFF  = 2'd0,
        CTRL_IDLE = 2'd1,
        CTRL_RECV = 2'd2,
        CTRL_HOLD = 2'd3
    } ctrl_state_e;

    // Four characters of line idle at 8x oversampling (10 bits x 8 x 4).
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 320;

    function automatic logic rx_en_for(input ctrl_state_e st);
        return (st == CTRL_IDLE) || (st == CTRL_RECV);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a registered head byte, so a push in cycle N
// shows on head/valid in cycle N+1.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    head_q, head_d;
    logic          valid_q, valid_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == LW'(0));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next-state for storage, pointers, level and the registered head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // The incoming byte becomes head only when nothing older survives this cycle.
        if (push_ok_s && (empty || (pop_ok_s && (level_q == LW'(1))))) begin
            head_d = din;
        end else if (pop_ok_s && (level_q > LW'(1))) begin
            head_d = mem_q[rd_ptr_d];
        end else begin
            head_d = head_q;
        end
        valid_d = (level_d != LW'(0));
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            level_q  <= LW'(0);
            head_q   <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign level = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences one uart_rx: gates rx_en, captures each finished byte into a FIFO,
// streams it out over valid/ready and flags overrun and idle timeout.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEFAULT,
    parameter bit          HOLD_ON_FULL = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ctrl_en,
    input  logic                          rx_start,
    input  logic                          rx_busy,
    input  logic                          rx_done,
    input  logic [7:0]                    rx_byte,
    output logic                          rx_en,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          timeout_irq
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    ctrl_state_e   state_q, state_d;
    logic          rx_en_q, rx_en_d;
    logic          rx_done_q;
    logic          overrun_q, overrun_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_irq_q, tmo_irq_d;

    logic          capture_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          fifo_valid_s;
    logic          tmo_run_s;

    // rx_data_out is only stable on the cycle after done falls, so capture exactly there.
    assign capture_s = rx_done_q && !rx_done && (state_q == CTRL_RECV);
    assign pop_s     = fifo_valid_s && m_ready;
    assign tmo_run_s = (state_q == CTRL_IDLE) || (state_q == CTRL_HOLD);

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (capture_s),
        .din   (rx_byte),
        .pop   (pop_s),
        .head  (m_data),
        .valid (fifo_valid_s),
        .level (fifo_level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Controller next state; a frame in progress always completes before OFF.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CTRL_OFF: begin
                if (ctrl_en) state_d = CTRL_IDLE;
                else         state_d = CTRL_OFF;
            end
            CTRL_IDLE: begin
                if (!ctrl_en)                        state_d = CTRL_OFF;
                else if (HOLD_ON_FULL && fifo_full_s) state_d = CTRL_HOLD;
                else if (rx_busy)                    state_d = CTRL_RECV;
                else                                 state_d = CTRL_IDLE;
            end
            CTRL_RECV: begin
                if (capture_s) state_d = ctrl_en ? CTRL_IDLE : CTRL_OFF;
                else           state_d = CTRL_RECV;
            end
            CTRL_HOLD: begin
                if (!ctrl_en)                   state_d = CTRL_OFF;
                else if (!fifo_full_s || pop_s) state_d = CTRL_IDLE;
                else                            state_d = CTRL_HOLD;
            end
            default: state_d = CTRL_OFF;
        endcase
        rx_en_d = rx_en_for(state_d);
    end

    // Overrun: a new loss outranks a clear in the same cycle.
    always_comb begin
        if (capture_s && fifo_full_s && !pop_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Idle timeout counter; the pulse marks the single step onto the saturation value.
    always_comb begin
        tmo_irq_d = 1'b0;
        if (capture_s || rx_start || fifo_empty_s) begin
            tmo_cnt_d = CW'(0);
        end else if (tmo_run_s && (tmo_cnt_q != CW'(TIMEOUT_CYC))) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
            tmo_irq_d = (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Controller FSM and its registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CTRL_OFF;
            rx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_en_q <= rx_en_d;
        end
    end

    // Done edge detector, overrun flag and timeout registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_q <= 1'b0;
            overrun_q <= 1'b0;
            tmo_cnt_q <= CW'(0);
            tmo_irq_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            overrun_q <= overrun_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_irq_q <= tmo_irq_d;
        end
    end

    assign rx_en       = rx_en_q;
    assign m_valid     = fifo_valid_s;
    assign overrun     = overrun_q;
    assign timeout_irq = tmo_irq_q;

endmodule
